// File: rtl/fmul_pre_norm_pipe.sv
// Two-stage pre-normaliser for the FPU multiply/divide path: unpacks fractions,
// forms the biased result exponent with its range flags, under valid/ready flow control.
module fmul_pre_norm_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_div,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [EXP_W+FRAC_W:0] opa,
  input  logic [EXP_W+FRAC_W:0] opb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_W-1:0]      out_tag,
  output logic [FRAC_W:0]       fracta,
  output logic [FRAC_W:0]       fractb,
  output logic [EXP_W-1:0]      exp_out,
  output logic                  sign,
  output logic                  sign_exe,
  output logic                  inf,
  output logic [1:0]            exp_ovf,
  output logic [2:0]            underflow,
  output logic                  zero_a,
  output logic                  zero_b
);
  localparam int E = EXP_W;
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [E-1:0] BIAS    = {1'b0, {(E-1){1'b1}}};
  localparam logic [E:0]   BIAS_X  = {1'b0, BIAS};
  localparam logic [E-1:0] ONE     = {{(E-1){1'b0}}, 1'b1};
  localparam logic [E+1:0] INF_LIM = {2'b00, BIAS} + {1'b0, BIAS, 1'b0};

  logic             s1_valid_q, s1_div_q, s2_valid_q;
  logic [TAG_W-1:0] s1_tag_q, out_tag_q;
  logic [W-1:0]     s1_opa_q, s1_opb_q;
  logic [FRAC_W:0]  fracta_q, fractb_q, fracta_d, fractb_d;
  logic [E-1:0]     exp_out_q, exp_out_d;
  logic             sign_q, sign_exe_q, inf_q, inf_d, zero_a_q, zero_b_q;
  logic [1:0]       exp_ovf_q, exp_ovf_d;
  logic [2:0]       underflow_q, underflow_d;

  logic s2_adv, accept;
  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready & ~flush;

  logic [E-1:0]      expa, expb, t1, t2, t3, t4, t5;
  logic [FRAC_W-1:0] fraca, fracb;
  logic [E:0]        sum1, sum2;
  logic              co1, co2, expa_dn, expb_dn, dn, opa_00, opb_00, msb_a, msb_b;

  assign expa    = s1_opa_q[W-2:FRAC_W];
  assign expb    = s1_opb_q[W-2:FRAC_W];
  assign fraca   = s1_opa_q[FRAC_W-1:0];
  assign fracb   = s1_opb_q[FRAC_W-1:0];
  assign msb_a   = expa[E-1];
  assign msb_b   = expb[E-1];
  assign expa_dn = ~|expa;
  assign expb_dn = ~|expb;
  assign dn      = expa_dn | expb_dn;
  assign opa_00  = ~|s1_opa_q[W-2:0];
  assign opb_00  = ~|s1_opb_q[W-2:0];

  // Exponent arithmetic is one bit wider than the field so the carries survive.
  assign sum1 = s1_div_q ? ({1'b0, expa} - {1'b0, expb}) : ({1'b0, expa} + {1'b0, expb});
  assign sum2 = s1_div_q ? (sum1 + BIAS_X) : (sum1 - BIAS_X);
  assign {co1, t1} = sum1;
  assign {co2, t2} = sum2;
  assign t3 = t2 + ONE;
  assign t4 = BIAS - t1;
  assign t5 = s1_div_q ? (t4 + ONE) : (t4 - ONE);

  assign exp_ovf_d = s1_div_q ? {co2, msb_a & ~msb_b}
                              : {(~msb_a & ~msb_b & t2[E-1]) | co2, co2 & msb_a & msb_b};
  assign exp_out_d = s1_div_q ? (dn ? (co2 ? t5 : t3) : (co2 ? t4 : t2))
                              : (exp_ovf_d[1] ? (dn ? t5 : t4) : (dn ? t3 : t2));
  assign underflow_d[0] = (t1 < BIAS) & ~co1 & ~(opa_00 | opb_00 | dn);
  assign underflow_d[1] = ((msb_a | msb_b) & ~opa_00 & ~opb_00)
                        | (expa_dn & |fraca) | (expb_dn & |fracb);
  assign underflow_d[2] = ~opa_00 & ~opb_00 & (t1 == BIAS);
  assign inf_d    = s1_div_q ? (expb_dn & ~msb_a) : ({1'b0, sum1} > INF_LIM);
  assign fracta_d = {~expa_dn, fraca};
  assign fractb_d = {~expb_dn, fracb};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_div_q    <= 1'b0;
      s1_tag_q    <= '0;
      s1_opa_q    <= '0;
      s1_opb_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_tag_q   <= '0;
      fracta_q    <= '0;
      fractb_q    <= '0;
      exp_out_q   <= '0;
      sign_q      <= 1'b0;
      sign_exe_q  <= 1'b0;
      inf_q       <= 1'b0;
      exp_ovf_q   <= '0;
      underflow_q <= '0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
    end else begin
      if (flush)       s1_valid_q <= 1'b0;
      else if (accept) s1_valid_q <= 1'b1;
      else if (s2_adv) s1_valid_q <= 1'b0;
      if (accept) begin
        s1_div_q <= in_div;
        s1_tag_q <= in_tag;
        s1_opa_q <= opa;
        s1_opb_q <= opb;
      end
      if (flush)          s2_valid_q <= 1'b0;
      else if (s2_adv)    s2_valid_q <= 1'b1;
      else if (out_ready) s2_valid_q <= 1'b0;
      // Output fields only move on advance, so they stay frozen while stalled.
      if (s2_adv) begin
        out_tag_q   <= s1_tag_q;
        fracta_q    <= fracta_d;
        fractb_q    <= fractb_d;
        exp_out_q   <= exp_out_d;
        sign_q      <= s1_opa_q[W-1] ^ s1_opb_q[W-1];
        sign_exe_q  <= s1_opa_q[W-1] & s1_opb_q[W-1];
        inf_q       <= inf_d;
        exp_ovf_q   <= exp_ovf_d;
        underflow_q <= underflow_d;
        zero_a_q    <= opa_00;
        zero_b_q    <= opb_00;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_tag   = out_tag_q;
  assign fracta    = fracta_q;
  assign fractb    = fractb_q;
  assign exp_out   = exp_out_q;
  assign sign      = sign_q;
  assign sign_exe  = sign_exe_q;
  assign inf       = inf_q;
  assign exp_ovf   = exp_ovf_q;
  assign underflow = underflow_q;
  assign zero_a    = zero_a_q;
  assign zero_b    = zero_b_q;
endmodule

// File: tb/tb_fmul_pre_norm_pipe.sv
// Testbench for fmul_pre_norm_pipe (FP32 configuration): directed test-plan vectors,
// backpressure, flush, reset and a random stream checked through a scoreboard queue.
module tb_fmul_pre_norm_pipe;
  localparam int E    = 8;
  localparam int F    = 23;
  localparam int T    = 4;
  localparam int W    = 1 + E + F;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int OW   = T + 2 * (F + 1) + E + 10;

  logic clk = 1'b0;
  logic reset = 1'b0, flush = 1'b0, in_valid = 1'b0, in_div = 1'b0, out_ready = 1'b1;
  logic [T-1:0] in_tag = '0;
  logic [W-1:0] opa = '0, opb = '0;
  logic in_ready, out_valid, sign, sign_exe, inf, zero_a, zero_b;
  logic [T-1:0] out_tag;
  logic [F:0] fracta, fractb;
  logic [E-1:0] exp_out;
  logic [1:0] exp_ovf;
  logic [2:0] underflow;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] sb[$];
  logic [OW-1:0] snap = '0;
  logic stall_q = 1'b0;

  wire [OW-1:0] dut_rec = {out_tag, fracta, fractb, exp_out, sign, sign_exe, inf,
                           exp_ovf, underflow, zero_a, zero_b};

  fmul_pre_norm_pipe #(.EXP_W(E), .FRAC_W(F), .TAG_W(T)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_div(in_div), .in_tag(in_tag),
    .opa(opa), .opb(opb),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .fracta(fracta), .fractb(fractb), .exp_out(exp_out),
    .sign(sign), .sign_exe(sign_exe), .inf(inf), .exp_ovf(exp_ovf),
    .underflow(underflow), .zero_a(zero_a), .zero_b(zero_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model written from the arithmetic definitions using plain integers.
  function automatic logic [OW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic d, input logic [T-1:0] tg);
    int ea, eb, s1, s2, t1, t2, t3, t4, t5, eo, H, M;
    bit co1, co2, am, bm, adn, bdn, dn, a00, b00, o0, o1, u0, u1, u2, inf_v;
    logic [E-1:0] eo_v;
    H = 1 << E;
    M = 1 << (E + 1);
    ea = int'(a[W-2:F]);
    eb = int'(b[W-2:F]);
    s1 = d ? ea - eb : ea + eb;
    s1 = (s1 + M) % M;
    co1 = (s1 >= H);
    t1 = s1 % H;
    s2 = d ? s1 + BIAS : s1 - BIAS;
    s2 = (s2 + M) % M;
    co2 = (s2 >= H);
    t2 = s2 % H;
    t3 = (t2 + 1) % H;
    t4 = (BIAS - t1 + H) % H;
    t5 = d ? (t4 + 1) % H : (t4 + H - 1) % H;
    am = ea >= H / 2;
    bm = eb >= H / 2;
    adn = (ea == 0);
    bdn = (eb == 0);
    dn = adn || bdn;
    a00 = (a[W-2:0] == 0);
    b00 = (b[W-2:0] == 0);
    o0 = d ? (am && !bm) : (co2 && am && bm);
    o1 = d ? co2 : ((!am && !bm && t2 >= H / 2) || co2);
    if (d) eo = dn ? (co2 ? t5 : t3) : (co2 ? t4 : t2);
    else   eo = o1 ? (dn ? t5 : t4) : (dn ? t3 : t2);
    u0 = (t1 < BIAS) && !co1 && !(a00 || b00 || dn);
    u1 = ((am || bm) && !a00 && !b00) || (adn && a[F-1:0] != 0) || (bdn && b[F-1:0] != 0);
    u2 = !a00 && !b00 && (t1 == BIAS);
    inf_v = d ? (bdn && !am) : (s1 > 3 * BIAS);
    eo_v = eo[E-1:0];
    return {tg, !adn, a[F-1:0], !bdn, b[F-1:0], eo_v, a[W-1] ^ b[W-1], a[W-1] & b[W-1],
            inf_v, o1, o0, u2, u1, u0, a00, b00};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0: v[W-2:F] = '0;
      1: v[W-2:0] = '0;
      2: v[W-2:F] = E'(BIAS);
      3: v[W-2:F] = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // One clock cycle: scoreboard work at the falling edge, then realign to posedge+1.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      if (out_valid && stall_q) chk("hold_stable", dut_rec, snap);
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("scoreboard", dut_rec, sb.pop_front());
      end
      stall_q = out_valid && !out_ready;
      snap = dut_rec;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(opa, opb, in_div, in_tag));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic d,
                       input logic [T-1:0] tg);
    opa = a; opb = b; in_div = d; in_tag = tg; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) tick();
    chk("drained_queue", sb.size(), 0);
    chk("drained_valid", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", dut_rec, 0);
    reset = 1'b1;
    tick();

    // FP32 mul 2.0 * 3.0, tag 5: valid exactly two cycles after acceptance.
    drive(32'h40000000, 32'h40400000, 1'b0, 4'd5);
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("mul_tag", out_tag, 5);
    chk("mul_fracta", fracta, 24'h800000);
    chk("mul_fractb", fractb, 24'hC00000);
    chk("mul_exp", exp_out, 8'h81);
    chk("mul_sign", sign, 0);
    chk("mul_inf", inf, 0);
    chk("mul_ovf", exp_ovf, 2'b00);
    chk("mul_uf", underflow, 3'b010);

    drive(32'h40C00000, 32'h40000000, 1'b1, 4'd6);
    tick();
    chk("div_exp", exp_out, 8'h80);
    chk("div_ovf", exp_ovf, 2'b00);
    chk("div_inf", inf, 0);
    chk("div_uf1", underflow[1], 1);

    drive(32'hBF800000, 32'hBF800000, 1'b0, 4'd7);
    tick();
    chk("neg_exp", exp_out, 8'h7F);
    chk("neg_sign", sign, 0);
    chk("neg_sign_exe", sign_exe, 1);
    chk("neg_uf", underflow, 3'b000);
    chk("neg_zeros", {zero_a, zero_b}, 2'b00);

    drive(32'h7F000000, 32'h7F000000, 1'b0, 4'd8);
    tick();
    chk("big_ovf", exp_ovf, 2'b11);
    chk("big_inf", inf, 1);
    chk("big_exp", exp_out, 8'h83);

    drive(32'h00000000, 32'h3F800000, 1'b0, 4'd9);
    tick();
    chk("zero_flags", {zero_a, zero_b}, 2'b10);
    tick();

    // Backpressure: third back-to-back beat must wait for out_ready.
    out_ready = 1'b0;
    opa = 32'h40000000; opb = 32'h3F800000; in_div = 1'b0; in_tag = 4'd1; in_valid = 1'b1;
    #1 chk("bp_ready1", in_ready, 1);
    tick();
    opa = 32'hC0400000; in_tag = 4'd2;
    chk("bp_ready2", in_ready, 1);
    tick();
    opa = 32'h3E800000; opb = 32'h40800000; in_div = 1'b1; in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_blocked", in_ready, 0);
      chk("bp_frozen_tag", out_tag, 1);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_released", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    // Flush with two beats in flight; the beat offered during flush is ignored.
    out_ready = 1'b0;
    drive(32'h41000000, 32'h40000000, 1'b0, 4'd10);
    drive(32'h41100000, 32'h40000000, 1'b1, 4'd11);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'd12;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_idle", out_valid, 0);
      tick();
    end
    chk("flush_queue", sb.size(), 0);

    // Random stream with random backpressure and stalls on the input side.
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_div    = 1'($urandom_range(0, 1));
      in_tag    = T'($urandom);
      opa       = rnd_op();
      opb       = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream, between clock edges.
    out_ready = 1'b0;
    drive(32'h40A00000, 32'h40000000, 1'b0, 4'd13);
    drive(32'h40A00000, 32'h40400000, 1'b1, 4'd14);
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_outputs", dut_rec, 0);
    sb.delete();
    stall_q = 1'b0;
    #1 reset = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(32'h3FC00000, 32'hC0000000, 1'b0, 4'd15);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_tag", out_tag, 15);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
